pgm_gfx_rom_cache: RTL and testbench
====================================

// Module: pgm_gfx_rom_cache
// PURPOSE
//  Read-only line cache between the video engine's graphics-ROM read port and the MiSTer DDRAM interface.
//  Sprite row and tile row fetches often re-read the same 32-byte region within a scanline; hits return in 2 cycles.
//  Misses issue one 4-beat DDRAM burst and fill a direct-mapped line.
//  Directly upstream of pgm_video: drives its ddram_* inputs and consumes its ddram_rd/ddram_addr.
// PARAMETERS
//  LINES       8   cache lines, power of 2; index = vid_addr[2+:$clog2(LINES)]
//  BURST_LEN   4   64-bit beats per line, fixed at 4; offset = vid_addr[1:0]
//  DRAIN_CYC   64  cycles after reset during which stray DDRAM beats are discarded
// PORTS
//  clk               in   1   single clock for video and DDRAM sides
//  reset             in   1   synchronous, active-high
//  flush             in   1   pulse; invalidates all lines (gfx ROM reload)
//  vid_rd            in   1   level request; held until vid_dout_ready, then dropped
//  vid_addr          in   29  64-bit word address; stable while vid_rd=1
//  vid_dout          out  64  read data; valid when vid_dout_ready=1, held afterwards
//  vid_busy          out  1   high in every state except IDLE
//  vid_dout_ready    out  1   1-cycle completion pulse
//  DDRAM_BUSY        in   1   controller back-pressure
//  DDRAM_RD          out  1   1-cycle burst read strobe
//  DDRAM_ADDR        out  29  line base address, {tag,index,2'b00}
//  DDRAM_BURSTCNT    out  8   constant BURST_LEN
//  DDRAM_DOUT        in   64  burst beat data
//  DDRAM_DOUT_READY  in   1   beat valid
//  DDRAM_WE / DDRAM_BE / DDRAM_DIN  out 1/8/64  tied 0 / 8'hFF / 0
// BEHAVIOUR
//  Reset: all outputs 0 except DDRAM_BURSTCNT=4 and DDRAM_BE=FF; vid_busy=1; all valid bits clear; state DRAIN.
//  DRAIN: DRAIN_CYC cycles; DDRAM_DOUT_READY ignored; then IDLE.
//  IDLE: vid_rd=1 -> latch vid_addr and go to LOOKUP. vid_busy=0 in this state only.
//  LOOKUP: registered tag/valid read. Hit -> RESPOND. Miss -> MISS_REQ.
//  MISS_REQ: assert DDRAM_RD for exactly one cycle, on the first cycle with DDRAM_BUSY=0, with line base address. Then MISS_FILL with beat=0.
//  MISS_FILL: each DDRAM_DOUT_READY writes data[index][beat] and increments beat (2-bit).
//   Beat==offset -> capture into vid_dout. After beat 3 -> RESPOND.
//   Tag/valid write: on beat 3 only, and only if no flush occurred during the miss (flush wins).
//  RESPOND: vid_dout_ready=1 for one cycle -> RELEASE.
//  RELEASE: wait for vid_rd=0 -> IDLE. A rd still held never causes a duplicate response.
//  Hit latency: vid_dout_ready 2 cycles after the IDLE cycle that sampled vid_rd.
//   A hit with vid_rd raised at cycle N gives a pulse at N+2.
//  Miss latency: 3 cycles + DDRAM latency + 4 beats.
//  flush in any state: clears every valid bit on the next edge; an in-flight miss still completes and returns data.
//  DDRAM_DOUT_READY outside DRAIN/MISS_FILL: discarded, no state change.
//  Replacement: direct-mapped; a miss overwrites the line unconditionally.
// STRUCTURE
//  pgm_video_pkg: state enum {DRAIN,IDLE,LOOKUP,MISS_REQ,MISS_FILL,RESPOND,RELEASE}, GFX_BURST_LEN=4,
//   gfx_addr_t (29b) with tag/index/offset field helpers.
//  Sub-module pgm_gfx_cache_ram: simple dual-port RAM, LINES*4 x 64b, registered read.
//  Tags and valid bits live in flops inside this block (single-cycle flush).
// TESTING
//  Cold miss: vid_rd @0x0001_0005 -> one DDRAM_RD, ADDR=0x0001_0004, BURSTCNT=4.
//   Beats 0..3 = A0..A3 -> vid_dout=A1 with a single ready pulse.
//  Hit after fill: read 0x0001_0007 -> no DDRAM_RD; ready exactly 2 cycles after vid_rd; vid_dout=A3.
//  Conflict: read 0x0002_0004 (same index, new tag) -> miss refill.
//   A following read of 0x0001_0004 -> miss again.
//  Back-pressure: DDRAM_BUSY=1 for 10 cycles -> DDRAM_RD held 0, then exactly one 1-cycle strobe.
//  Flush mid-fill: flush between beats 1 and 2 -> data still returned; a re-read of the same address misses.
//  Reset mid-burst: reset after beat 1, then 2 stray beats ->
//   vid_busy=1 for DRAIN_CYC cycles; the next request misses and gets correct data.

Source files
------------

// File: rtl/pgm_video_pkg.sv
// pgm_video_pkg: shared state encoding, burst length and gfx-ROM address field helpers
package pgm_video_pkg;
    localparam int GFX_BURST_LEN = 4;
    typedef logic [28:0] gfx_addr_t;
    typedef enum logic [2:0] {DRAIN, IDLE, LOOKUP, MISS_REQ, MISS_FILL, RESPOND, RELEASE} cache_state_t;
    function automatic logic [1:0] gfx_offset(input gfx_addr_t a);
        return a[1:0];
    endfunction
    function automatic logic [26:0] gfx_line_num(input gfx_addr_t a);
        return a[28:2];
    endfunction
    function automatic gfx_addr_t gfx_line_base(input gfx_addr_t a);
        return {a[28:2], 2'b00};
    endfunction
endpackage

// File: rtl/pgm_gfx_cache_ram.sv
// pgm_gfx_cache_ram: simple dual-port line data store with registered read
//   clk          single clock
//   we/waddr/wdata   write port (one 64-bit beat per cycle)
//   raddr/rdata      read port, data one cycle after the address
module pgm_gfx_cache_ram #(
    parameter int DEPTH = 32,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [63:0]   wdata,
    input  logic [AW-1:0] raddr,
    output logic [63:0]   rdata
);
    logic [63:0] mem [DEPTH];
    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
        rdata <= mem[raddr];
    end
endmodule

// File: rtl/pgm_gfx_rom_cache.sv
// pgm_gfx_rom_cache: direct-mapped read-only line cache between the video engine's
// gfx-ROM read port and the MiSTer DDRAM burst interface.
//   clk, reset           single clock, synchronous active-high reset
//   flush                pulse, invalidates every line
//   vid_rd, vid_addr     level request and 64-bit word address
//   vid_dout             read data, held after the completion pulse
//   vid_dout_ready       1-cycle completion pulse
//   vid_busy             low only while idle
//   DDRAM_*              burst read master, write side tied off
module pgm_gfx_rom_cache
    import pgm_video_pkg::*;
#(
    parameter int LINES     = 8,
    parameter int BURST_LEN = GFX_BURST_LEN,
    parameter int DRAIN_CYC = 64
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        flush,
    input  logic        vid_rd,
    input  logic [28:0] vid_addr,
    output logic [63:0] vid_dout,
    output logic        vid_busy,
    output logic        vid_dout_ready,
    input  logic        DDRAM_BUSY,
    output logic        DDRAM_RD,
    output logic [28:0] DDRAM_ADDR,
    output logic [7:0]  DDRAM_BURSTCNT,
    input  logic [63:0] DDRAM_DOUT,
    input  logic        DDRAM_DOUT_READY,
    output logic        DDRAM_WE,
    output logic [7:0]  DDRAM_BE,
    output logic [63:0] DDRAM_DIN
);
    localparam int IW = $clog2(LINES);
    localparam int TW = 27 - IW;
    localparam int DW = $clog2(DRAIN_CYC);
    cache_state_t state, state_nx;
    gfx_addr_t addr;
    logic [DW-1:0] drain_cnt;
    logic [1:0] beat;
    logic flush_seen;
    logic [LINES-1:0] valid;
    logic [TW-1:0] tags [LINES];
    logic [63:0] rdata;
    logic [26:0] line;
    logic [IW-1:0] idx;
    logic [TW-1:0] tag;
    logic hit, beat_in, fill_done;
    assign line = gfx_line_num(addr);
    assign idx = line[IW-1:0];
    assign tag = line[26:IW];
    assign hit = valid[idx] && tags[idx] == tag;
    assign beat_in = state == MISS_FILL && DDRAM_DOUT_READY;
    assign fill_done = beat_in && beat == 2'd3;
    // Read port follows the live request so the IDLE cycle that accepts it
    // already has the data word ready for LOOKUP.
    pgm_gfx_cache_ram #(.DEPTH(LINES * GFX_BURST_LEN)) u_ram (
        .clk(clk),
        .we(beat_in),
        .waddr({idx, beat}),
        .wdata(DDRAM_DOUT),
        .raddr({vid_addr[2+:IW], gfx_offset(vid_addr)}),
        .rdata(rdata)
    );
    always_comb begin
        state_nx = state;
        case (state)
            DRAIN:     if (drain_cnt == DW'(DRAIN_CYC - 1)) state_nx = IDLE;
            IDLE:      if (vid_rd) state_nx = LOOKUP;
            LOOKUP:    state_nx = hit ? RESPOND : MISS_REQ;
            MISS_REQ:  if (!DDRAM_BUSY) state_nx = MISS_FILL;
            MISS_FILL: if (fill_done) state_nx = RESPOND;
            RESPOND:   state_nx = RELEASE;
            RELEASE:   if (!vid_rd) state_nx = IDLE;
            default:   state_nx = IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= DRAIN;
            addr       <= '0;
            drain_cnt  <= '0;
            beat       <= '0;
            flush_seen <= 1'b0;
            vid_dout   <= '0;
        end else begin
            state <= state_nx;
            if (state == DRAIN) drain_cnt <= drain_cnt + 1'b1;
            if (state == IDLE && vid_rd) addr <= vid_addr;
            if (beat_in) beat <= beat + 1'b1;
            // Any flush between request acceptance and the last beat keeps the refilled line invalid.
            flush_seen <= (state == IDLE) ? 1'b0 : (flush_seen | flush);
            if (state == LOOKUP && hit) vid_dout <= rdata;
            if (beat_in && beat == gfx_offset(addr)) vid_dout <= DDRAM_DOUT;
        end
    end
    always_ff @(posedge clk) begin
        if (reset || flush) valid <= '0;
        else if (fill_done && !flush_seen) valid[idx] <= 1'b1;
        if (fill_done) tags[idx] <= tag;
    end
    assign vid_busy       = state != IDLE;
    assign vid_dout_ready = state == RESPOND;
    assign DDRAM_RD       = state == MISS_REQ && !DDRAM_BUSY;
    assign DDRAM_ADDR     = gfx_line_base(addr);
    assign DDRAM_BURSTCNT = 8'(BURST_LEN);
    assign DDRAM_WE       = 1'b0;
    assign DDRAM_BE       = 8'hFF;
    assign DDRAM_DIN      = '0;
endmodule

// File: tb/tb_pgm_gfx_rom_cache.sv
// tb_pgm_gfx_rom_cache: randomized self-checking bench with a DDRAM responder and a line-map cache model
module tb_pgm_gfx_rom_cache;
    localparam int LINES = 8;
    localparam int DRAIN = 64;
    logic clk = 1'b0;
    logic reset = 1'b1, flush = 1'b0, vid_rd = 1'b0;
    logic [28:0] vid_addr = '0;
    logic [63:0] vid_dout;
    logic vid_busy, vid_dout_ready;
    logic DDRAM_BUSY = 1'b0, DDRAM_RD, DDRAM_WE, DDRAM_DOUT_READY = 1'b0;
    logic [28:0] DDRAM_ADDR;
    logic [7:0] DDRAM_BURSTCNT, DDRAM_BE;
    logic [63:0] DDRAM_DOUT = '0, DDRAM_DIN;
    int checks = 0, errors = 0;
    int rd_cnt = 0;
    logic [28:0] rd_addr = '0;
    logic [7:0] rd_bc = '0;
    bit auto_en = 1'b1;
    int beats_sent = 0;
    int gap_fix = -1;
    logic [31:0] seed;
    logic [28:0] cached [int];

    pgm_gfx_rom_cache dut (
        .clk(clk), .reset(reset), .flush(flush), .vid_rd(vid_rd), .vid_addr(vid_addr),
        .vid_dout(vid_dout), .vid_busy(vid_busy), .vid_dout_ready(vid_dout_ready),
        .DDRAM_BUSY(DDRAM_BUSY), .DDRAM_RD(DDRAM_RD), .DDRAM_ADDR(DDRAM_ADDR),
        .DDRAM_BURSTCNT(DDRAM_BURSTCNT), .DDRAM_DOUT(DDRAM_DOUT),
        .DDRAM_DOUT_READY(DDRAM_DOUT_READY), .DDRAM_WE(DDRAM_WE), .DDRAM_BE(DDRAM_BE),
        .DDRAM_DIN(DDRAM_DIN)
    );

    always #5 clk = ~clk;

    function automatic logic [63:0] mem(input logic [28:0] a);
        return {(32'(a) * 32'h9E37_79B1) ^ seed, 32'(a) ^ ~seed};
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (DDRAM_RD === 1'b1) begin
            rd_cnt++;
            rd_addr = DDRAM_ADDR;
            rd_bc = DDRAM_BURSTCNT;
        end
    end

    initial forever begin
        @(negedge clk);
        if (auto_en && DDRAM_RD === 1'b1) begin
            logic [28:0] b;
            b = DDRAM_ADDR;
            beats_sent = 0;
            @(negedge clk);
            repeat ($urandom_range(0, 3)) @(negedge clk);
            for (int k = 0; k < 4; k++) begin
                DDRAM_DOUT = mem(b + 29'(k));
                DDRAM_DOUT_READY = 1'b1;
                @(negedge clk);
                DDRAM_DOUT_READY = 1'b0;
                beats_sent = k + 1;
                if (k < 3) repeat (gap_fix >= 0 ? gap_fix : int'($urandom_range(0, 1))) @(negedge clk);
            end
        end
    end

    task automatic do_read(input logic [28:0] a, input int busy_cyc, input bit flush_mid, input int hold, input string name);
        int idx, rd0, cyc, extra;
        logic [28:0] base;
        bit exp_hit, seen, flushed;
        idx = int'(a[28:2]) % LINES;
        base = a & ~29'h3;
        exp_hit = cached.exists(idx) && cached[idx] == base;
        checks++;
        if (vid_busy !== 1'b0) begin errors++; $display("FAIL %s idle_busy: got %b want 0", name, vid_busy); end
        rd0 = rd_cnt;
        beats_sent = 0;
        gap_fix = flush_mid ? 2 : -1;
        DDRAM_BUSY = busy_cyc > 0;
        vid_addr = a;
        vid_rd = 1'b1;
        cyc = 0;
        seen = 0;
        flushed = 0;
        while (!seen && cyc < 200) begin
            flush = flush_mid && !flushed && beats_sent >= 2;
            if (flush) flushed = 1;
            tick;
            flush = 1'b0;
            cyc++;
            if (cyc == busy_cyc) begin
                checks++;
                if (rd_cnt != rd0) begin errors++; $display("FAIL %s bp_hold: got %0d strobes want 0", name, rd_cnt - rd0); end
                DDRAM_BUSY = 1'b0;
            end
            seen = vid_dout_ready === 1'b1;
        end
        DDRAM_BUSY = 1'b0;
        checks++;
        if (!seen) begin errors++; $display("FAIL %s ready_timeout: got no pulse in %0d cycles want pulse", name, cyc); end
        if (exp_hit) begin
            checks++;
            if (cyc != 2) begin errors++; $display("FAIL %s hit_latency: got %0d want 2", name, cyc); end
        end
        checks++;
        if (rd_cnt - rd0 != (exp_hit ? 0 : 1)) begin errors++; $display("FAIL %s rd_count: got %0d want %0d", name, rd_cnt - rd0, exp_hit ? 0 : 1); end
        if (!exp_hit) begin
            checks++;
            if (rd_addr !== base || rd_bc !== 8'd4) begin errors++; $display("FAIL %s rd_req: got addr %h cnt %0d want addr %h cnt 4", name, rd_addr, rd_bc, base); end
        end
        if (flush_mid) begin
            checks++;
            if (flushed !== 1'b1) begin errors++; $display("FAIL %s flush_applied: got %b want 1", name, flushed); end
        end
        checks++;
        if (vid_dout !== mem(a)) begin errors++; $display("FAIL %s data: got %h want %h", name, vid_dout, mem(a)); end
        extra = 0;
        tick;
        if (vid_dout_ready === 1'b1) extra++;
        repeat (hold) begin
            tick;
            if (vid_dout_ready === 1'b1) extra++;
        end
        vid_rd = 1'b0;
        tick;
        if (vid_dout_ready === 1'b1) extra++;
        checks++;
        if (extra != 0 || vid_dout !== mem(a)) begin errors++; $display("FAIL %s release: got %0d extra pulses dout %h want 0 pulses dout %h", name, extra, vid_dout, mem(a)); end
        if (!exp_hit) begin
            if (flush_mid) cached.delete();
            else cached[idx] = base;
        end
    endtask

    task automatic test_reset(input int stray);
        bit bad;
        bad = 0;
        vid_rd = 1'b0;
        flush = 1'b0;
        DDRAM_BUSY = 1'b0;
        reset = 1'b1;
        tick;
        tick;
        checks++;
        if ({vid_busy, vid_dout_ready, DDRAM_RD, DDRAM_WE, DDRAM_BE, DDRAM_BURSTCNT} !== {4'b1000, 8'hFF, 8'd4}) begin
            errors++;
            $display("FAIL reset_ctrl: got busy %b rdy %b rd %b we %b be %h cnt %0d want 1 0 0 0 ff 4", vid_busy, vid_dout_ready, DDRAM_RD, DDRAM_WE, DDRAM_BE, DDRAM_BURSTCNT);
        end
        checks++;
        if (DDRAM_ADDR !== '0 || vid_dout !== '0 || DDRAM_DIN !== '0) begin
            errors++;
            $display("FAIL reset_data: got addr %h dout %h din %h want all 0", DDRAM_ADDR, vid_dout, DDRAM_DIN);
        end
        reset = 1'b0;
        for (int i = 0; i < DRAIN; i++) begin
            if (vid_busy !== 1'b1 || vid_dout_ready !== 1'b0 || DDRAM_RD !== 1'b0) bad = 1;
            DDRAM_DOUT_READY = i >= 1 && i <= stray;
            DDRAM_DOUT = {$urandom, $urandom};
            tick;
        end
        DDRAM_DOUT_READY = 1'b0;
        checks++;
        if (bad) begin errors++; $display("FAIL drain_busy: got early idle or output activity want busy for %0d cycles", DRAIN); end
        checks++;
        if (vid_busy !== 1'b0) begin errors++; $display("FAIL drain_end: got busy %b want 0", vid_busy); end
        cached.delete();
    endtask

    task automatic test_cold_miss;
        do_read(29'h0001_0005, 0, 0, 0, "cold_miss");
    endtask

    task automatic test_hit;
        do_read(29'h0001_0007, 0, 0, 2, "hit");
    endtask

    task automatic test_stray_idle;
        bit bad;
        bad = 0;
        for (int i = 0; i < 3; i++) begin
            DDRAM_DOUT = {$urandom, $urandom};
            DDRAM_DOUT_READY = 1'b1;
            tick;
            if (vid_busy !== 1'b0 || vid_dout_ready !== 1'b0) bad = 1;
        end
        DDRAM_DOUT_READY = 1'b0;
        checks++;
        if (bad) begin errors++; $display("FAIL stray_idle: got state change on stray beats want none"); end
        do_read(29'h0001_0006, 0, 0, 0, "stray_then_hit");
    endtask

    task automatic test_conflict;
        do_read(29'h0002_0004, 0, 0, 0, "conflict_new_tag");
        do_read(29'h0001_0004, 0, 0, 1, "conflict_old_tag");
    endtask

    task automatic test_back_pressure;
        do_read(29'h0003_0010, 10, 0, 0, "back_pressure");
    endtask

    task automatic test_flush_mid_fill;
        do_read(29'h0004_0022, 0, 1, 0, "flush_fill");
        do_read(29'h0004_0022, 0, 0, 0, "flush_reread");
        do_read(29'h0001_0004, 0, 0, 0, "flush_other_line");
    endtask

    task automatic test_random;
        for (int n = 0; n < 80; n++) begin
            if ($urandom_range(0, 9) == 0) begin
                flush = 1'b1;
                tick;
                flush = 1'b0;
                cached.delete();
            end
            do_read(29'h0300_0000 + 29'($urandom_range(0, 95)),
                    $urandom_range(0, 3) == 0 ? int'($urandom_range(1, 3)) : 0,
                    0, int'($urandom_range(0, 2)), "random");
        end
    endtask

    task automatic test_reset_mid_burst;
        int cyc;
        auto_en = 1'b0;
        vid_addr = 29'h0005_0009;
        vid_rd = 1'b1;
        cyc = 0;
        while (DDRAM_RD !== 1'b1 && cyc < 50) begin
            tick;
            cyc++;
        end
        checks++;
        if (DDRAM_RD !== 1'b1) begin errors++; $display("FAIL midburst_rd: got %b want 1", DDRAM_RD); end
        tick;
        for (int k = 0; k < 2; k++) begin
            DDRAM_DOUT = mem(29'h0005_0008 + 29'(k));
            DDRAM_DOUT_READY = 1'b1;
            tick;
        end
        DDRAM_DOUT_READY = 1'b0;
        test_reset(2);
        auto_en = 1'b1;
        do_read(29'h0005_0009, 0, 0, 0, "after_reset_miss");
        do_read(29'h0005_000B, 0, 0, 0, "after_reset_hit");
    endtask

    initial begin
        seed = $urandom;
        test_reset(2);
        test_cold_miss;
        test_hit;
        test_stray_idle;
        test_conflict;
        test_back_pressure;
        test_flush_mid_fill;
        test_random;
        test_reset_mid_burst;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL global_timeout: got no finish within 40000 cycles want finish");
        $fatal(1, "bench stalled");
    end
endmodule
